// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer.
//   MODE_W     : width of the mode code
//   mode_e     : pattern modes (ROT_L, ROT_R, BOUNCE, FILL)
//   dir_e      : travel direction of the lit bit in BOUNCE mode
//   next_mode  : mode advance on a button press, wrapping FILL back to ROT_L
package led_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Four modes fill the 2-bit code, so plain 2-bit addition wraps 3 -> 0.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Bundle of the sequencer's user-facing signals.
//   i_switch : raw push-button level, high = pressed
//   o_led    : LED pattern, bit 0 = LED0
//   o_mode   : current mode code
// master = the side driving the button (board / bench), slave = the sequencer.
interface led_seq_if #(
    parameter int LED_COUNT = 4
) ();
    import led_seq_pkg::*;

    logic                 i_switch;
    logic [LED_COUNT-1:0] o_led;
    logic [MODE_W-1:0]    o_mode;

    modport master (output i_switch, input  o_led, input  o_mode);
    modport slave  (input  i_switch, output o_led, output o_mode);

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a persistence filter for a bouncing button.
//   i_clock           : system clock, rising edge
//   i_reset           : asynchronous active-high reset
//   i_switch          : raw asynchronous switch level
//   o_filtered_switch : debounced level, registered
// The filtered level flips only after the synchronised input has disagreed with
// it for DEBOUNCE_LIMIT consecutive cycles; one agreeing cycle restarts the count.
module switch_debounce
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 5000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_switch,
    output logic o_filtered_switch
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             level_q;
    logic             level_d;

    // Persistence counter and filtered-level next state.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        if (sync2_q != level_q) begin
            // The cycle that reaches CNT_MAX is the DEBOUNCE_LIMIT-th disagreeing one.
            if (count_q == CNT_MAX) begin
                level_d = sync2_q;
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, counter and filtered-level registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            level_q <= 1'b0;
        end else begin
            sync1_q <= i_switch;
            sync2_q <= sync1_q;
            count_q <= count_d;
            level_q <= level_d;
        end
    end

    assign o_filtered_switch = level_q;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven LED pattern sequencer.
//   i_clock  : system clock, rising edge
//   i_reset  : asynchronous active-high reset
//   i_switch : raw bouncing push-button, high = pressed
//   o_led    : registered LED pattern, bit 0 = LED0
//   o_mode   : registered mode code (0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL)
// A debounced press advances the mode and restarts the pattern at 1; between
// presses the pattern advances once every TICK_DIV cycles.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_COUNT      = 4,
    parameter int TICK_DIV       = 5000000,
    parameter int DEBOUNCE_LIMIT = 5000000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_switch,
    output logic [LED_COUNT-1:0] o_led,
    output logic [MODE_W-1:0]    o_mode
);

    localparam int                   TICK_W   = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0]    TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [LED_COUNT-1:0] LED_ONE  = LED_COUNT'(1);

    logic                 filtered_s;
    logic                 press_s;
    logic                 step_s;
    logic                 prev_level_q;
    logic [TICK_W-1:0]    tick_q;
    logic [TICK_W-1:0]    tick_d;
    logic [LED_COUNT-1:0] led_q;
    logic [LED_COUNT-1:0] led_d;
    mode_e                mode_q;
    mode_e                mode_d;
    dir_e                 dir_q;
    dir_e                 dir_d;

    // Shift-based rotates stay legal for a single LED, where they reduce to identity.
    function automatic logic [LED_COUNT-1:0] rot_left(input logic [LED_COUNT-1:0] v);
        return (v << 1) | (v >> (LED_COUNT - 1));
    endfunction

    function automatic logic [LED_COUNT-1:0] rot_right(input logic [LED_COUNT-1:0] v);
        return (v >> 1) | (v << (LED_COUNT - 1));
    endfunction

    switch_debounce #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_switch          (i_switch),
        .o_filtered_switch (filtered_s)
    );

    // Rising edge of the debounced level is a press; release is ignored.
    assign press_s = filtered_s & ~prev_level_q;
    assign step_s  = (tick_q == TICK_MAX);

    // Next state for tick counter, mode, direction and pattern.
    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        led_d  = led_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (press_s) begin
            // A press swallows any coincident step and restarts the step period.
            tick_d = {TICK_W{1'b0}};
            mode_d = next_mode(mode_q);
            led_d  = LED_ONE;
            dir_d  = DIR_LEFT;
        end else if (step_s) begin
            tick_d = {TICK_W{1'b0}};
            case (mode_q)
                MODE_ROT_L: led_d = rot_left(led_q);
                MODE_ROT_R: led_d = rot_right(led_q);
                MODE_BOUNCE: begin
                    if (LED_COUNT == 1) begin
                        led_d = LED_ONE;
                    end else if (dir_q == DIR_LEFT) begin
                        // Reverse from the top end so it stays lit for just one step.
                        if (led_q[LED_COUNT-1]) begin
                            led_d = led_q >> 1;
                            dir_d = DIR_RIGHT;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = led_q << 1;
                            dir_d = DIR_LEFT;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (&led_q) begin
                        led_d = {LED_COUNT{1'b0}};
                    end else begin
                        led_d = (led_q << 1) | LED_ONE;
                    end
                end
                default: led_d = LED_ONE;
            endcase
        end else begin
            led_d = led_q;
        end
    end

    // State registers; outputs come straight from these flops.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            prev_level_q <= 1'b0;
            tick_q       <= {TICK_W{1'b0}};
            led_q        <= LED_ONE;
            mode_q       <= MODE_ROT_L;
            dir_q        <= DIR_LEFT;
        end else begin
            prev_level_q <= filtered_s;
            tick_q       <= tick_d;
            led_q        <= led_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_q;

endmodule
